// File: rtl/fre_meas_pkg.sv
// Shared types and constants for the frequency-readout scheduler and its BCD converter.
package fre_meas_pkg;

    typedef enum logic [1:0] {ACCUM, AVG, BCD, WAIT_VS} state_t;

    localparam int DIGITS = 9;
    localparam int BCD_MAX_W = 36;
    localparam logic [BCD_MAX_W-1:0] BCD_MAX = BCD_MAX_W'(10**DIGITS - 1);

    // Double-dabble correction: a digit of 5 or more would carry wrongly on the next shift.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/fre_meas_scheduler_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per cycle, DATA_W steps per conversion.
module bin2bcd_seq
    import fre_meas_pkg::*;
#(
    parameter int DATA_W = 36,
    parameter int DIGITS = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  abort,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(DATA_W);

    logic                 running;
    logic [CNT_W-1:0]     step;
    logic [DATA_W-1:0]    bin_sr;
    logic [4*DIGITS-1:0]  bcd_adj;

    always_comb begin
        bcd_adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            bcd_adj[4*d +: 4] = add3(bcd[4*d +: 4]);
        end
    end

    assign done = running && (step == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            step    <= '0;
            bin_sr  <= '0;
            bcd     <= '0;
        end else if (abort) begin
            running <= 1'b0;
            step    <= '0;
        end else if (running) begin
            bcd    <= {bcd_adj[4*DIGITS-2:0], bin_sr[DATA_W-1]};
            bin_sr <= {bin_sr[DATA_W-2:0], 1'b0};
            step   <= step + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end else if (start) begin
            running <= 1'b1;
            step    <= '0;
            bin_sr  <= bin;
            bcd     <= '0;
        end
    end

endmodule

// File: rtl/fre_meas_scheduler.sv
// Averages FFT peak-frequency samples, converts to BCD and publishes on the vsync edge.
// Define FRE_PEAK_HOLD_EN to publish the maximum accepted sample instead of the mean.
module fre_meas_scheduler
    import fre_meas_pkg::*;
#(
    parameter int DATA_W      = 36,
    parameter int AVG_LOG2    = 10,
    parameter int REJECT_BITS = 5,
    parameter int DIGITS      = 9
) (
    input  logic                  lcd_pclk,
    input  logic                  sys_rst_n,
    input  logic [DATA_W-1:0]     samp_data,
    input  logic                  samp_valid,
    input  logic                  lcd_vs,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_upd,
    output logic                  busy,
    output logic                  sat,
    output logic                  drop_sticky
);

    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL = {1'b1, {AVG_LOG2{1'b0}}};
    localparam logic [DATA_W-1:0] CONV_MAX = DATA_W'(BCD_MAX);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_inc;
    logic                 vs_d, vs_rise, accept, sat_n;
    logic                 bcd_start, bcd_done;
    logic [DATA_W-1:0]    avg, conv_in;
    logic [4*DIGITS-1:0]  bcd_res;

    function automatic logic [DATA_W-1:0] sat_clip(input logic [DATA_W-1:0] v);
        return (v > CONV_MAX) ? CONV_MAX : v;
    endfunction

    assign accept  = samp_valid && !clr && (state == ACCUM) &&
                     (samp_data[DATA_W-1 -: REJECT_BITS] == '0);
    assign cnt_inc = cnt + 1'b1;
    assign vs_rise = lcd_vs && !vs_d;
    assign busy    = (state != ACCUM);
    assign conv_in = sat_clip(avg);

`ifdef FRE_PEAK_HOLD_EN
    logic [DATA_W-1:0] peak;

    assign avg = peak;

    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            peak <= '0;
        end else if (clr || state == AVG) begin
            peak <= '0;
        end else if (accept && samp_data > peak) begin
            peak <= samp_data;
        end
    end
`else
    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic [ACC_W-1:0] acc;

    assign avg = acc[ACC_W-1:AVG_LOG2];

    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc <= '0;
        end else if (clr || state == AVG) begin
            acc <= '0;
        end else if (accept) begin
            acc <= acc + ACC_W'(samp_data);
        end
    end
`endif

    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bcd_start = 1'b0;
        case (state)
            ACCUM:   if (accept && cnt_inc == CNT_FULL) state_nxt = AVG;
            AVG: begin
                bcd_start = 1'b1;
                state_nxt = BCD;
            end
            BCD:     if (bcd_done) state_nxt = WAIT_VS;
            WAIT_VS: if (vs_rise) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
        if (clr) begin
            state_nxt = ACCUM;
            bcd_start = 1'b0;
        end
    end

    // Published outputs only move on the vsync edge, so a digit never changes mid-frame.
    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt         <= '0;
            vs_d        <= 1'b0;
            sat_n       <= 1'b0;
            bcd_out     <= '0;
            sat         <= 1'b0;
            bcd_upd     <= 1'b0;
            drop_sticky <= 1'b0;
        end else begin
            vs_d    <= lcd_vs;
            bcd_upd <= 1'b0;
            if (clr) begin
                cnt         <= '0;
                drop_sticky <= 1'b0;
            end else begin
                if (samp_valid && state != ACCUM) drop_sticky <= 1'b1;
                if (accept) cnt <= cnt_inc;
                if (state == AVG) begin
                    sat_n <= (avg > CONV_MAX);
                    cnt   <= '0;
                end
                if (state == WAIT_VS && vs_rise) begin
                    bcd_out <= bcd_res;
                    sat     <= sat_n;
                    bcd_upd <= 1'b1;
                end
            end
        end
    end

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (lcd_pclk),
        .rst_n (sys_rst_n),
        .abort (clr),
        .start (bcd_start),
        .bin   (conv_in),
        .done  (bcd_done),
        .bcd   (bcd_res)
    );

endmodule

// File: tb/tb_fre_meas_scheduler.sv
// Randomised and directed bench for fre_meas_scheduler with a queue-based reference model.
module tb_fre_meas_scheduler;

    localparam int DATA_W      = 36;
    localparam int AVG_LOG2    = 2;
    localparam int REJECT_BITS = 5;
    localparam int DIGITS      = 9;
    localparam int NSAMP       = 1 << AVG_LOG2;
    localparam int CONV_WAIT   = 45;

    logic                 lcd_pclk;
    logic                 sys_rst_n;
    logic [DATA_W-1:0]    samp_data;
    logic                 samp_valid;
    logic                 lcd_vs;
    logic                 clr;
    logic [4*DIGITS-1:0]  bcd_out;
    logic                 bcd_upd;
    logic                 busy;
    logic                 sat;
    logic                 drop_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    fre_meas_scheduler #(
        .DATA_W      (DATA_W),
        .AVG_LOG2    (AVG_LOG2),
        .REJECT_BITS (REJECT_BITS),
        .DIGITS      (DIGITS)
    ) dut (
        .lcd_pclk    (lcd_pclk),
        .sys_rst_n   (sys_rst_n),
        .samp_data   (samp_data),
        .samp_valid  (samp_valid),
        .lcd_vs      (lcd_vs),
        .clr         (clr),
        .bcd_out     (bcd_out),
        .bcd_upd     (bcd_upd),
        .busy        (busy),
        .sat         (sat),
        .drop_sticky (drop_sticky)
    );

    initial lcd_pclk = 1'b0;
    always #5 lcd_pclk = ~lcd_pclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1);
    end

    // Reference model: decimal digits of the clipped mean (or max) of the accepted samples.
    function automatic logic [35:0] to_bcd(input longint unsigned v);
        logic [35:0] r = '0;
        longint unsigned t = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [35:0] model_bcd(input longint unsigned q[$], output logic s);
        longint unsigned r = 0;
        foreach (q[i]) begin
`ifdef FRE_PEAK_HOLD_EN
            if (q[i] > r) r = q[i];
`else
            r = r + q[i];
`endif
        end
`ifndef FRE_PEAK_HOLD_EN
        r = r / 64'(NSAMP);
`endif
        s = (r > 64'd999_999_999);
        if (s) r = 64'd999_999_999;
        return to_bcd(r);
    endfunction

    task automatic tick();
        @(posedge lcd_pclk);
        #1;
    endtask

    task automatic send_block(input logic [DATA_W-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            samp_data  = v;
            samp_valid = 1'b1;
            tick();
        end
        samp_valid = 1'b0;
    endtask

    task automatic idle(input int n, output int upd_seen);
        upd_seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bcd_upd === 1'b1) upd_seen++;
        end
    endtask

    task automatic vs_pulse(output int upd_seen);
        upd_seen = 0;
        lcd_vs = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bcd_upd === 1'b1) upd_seen++;
        end
        lcd_vs = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bcd_upd === 1'b1) upd_seen++;
        end
    endtask

    task automatic test_reset();
        sys_rst_n  = 1'b0;
        clr        = 1'b0;
        lcd_vs     = 1'b0;
        samp_valid = 1'b0;
        samp_data  = '0;
        repeat (3) tick();
        n_checks++; if (bcd_out !== 36'h0) begin n_fail++; $display("FAIL reset_bcd_out: got %h, required 0", bcd_out); end
        n_checks++; if (bcd_upd !== 1'b0) begin n_fail++; $display("FAIL reset_bcd_upd: got %b, required 0", bcd_upd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b, required 0", sat); end
        n_checks++; if (drop_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b, required 0", drop_sticky); end
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_average();
        logic [DATA_W-1:0] vals [4];
        logic [35:0] exp_bcd;
        int u;
        vals = '{36'd100, 36'd200, 36'd300, 36'd400};
`ifdef FRE_PEAK_HOLD_EN
        exp_bcd = 36'h000000400;
`else
        exp_bcd = 36'h000000250;
`endif
        for (int i = 0; i < 4; i++) send_block(vals[i], 1);
        idle(CONV_WAIT, u);
        n_checks++; if (u !== 0) begin n_fail++; $display("FAIL avg_early_upd: got %0d pulses before vsync, required 0", u); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL avg_busy_wait: got %b, required 1", busy); end
        vs_pulse(u);
        n_checks++; if (u !== 1) begin n_fail++; $display("FAIL avg_upd_count: got %0d, required 1", u); end
        n_checks++; if (bcd_out !== exp_bcd) begin n_fail++; $display("FAIL avg_bcd: got %h, required %h", bcd_out, exp_bcd); end
        n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL avg_sat: got %b, required 0", sat); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL avg_busy_after: got %b, required 0", busy); end
    endtask

    task automatic test_reject();
        int u;
        for (int i = 0; i < 4; i++) begin
            send_block((i % 2 == 0) ? 36'h0_8000_03E8 : 36'h8_0000_03E8, 1);
            samp_data = 36'd77;
            tick();
            send_block(36'd1000, 1);
        end
        idle(CONV_WAIT, u);
        vs_pulse(u);
        n_checks++; if (u !== 1) begin n_fail++; $display("FAIL reject_upd_count: got %0d, required 1", u); end
        n_checks++; if (bcd_out !== 36'h000001000) begin n_fail++; $display("FAIL reject_bcd: got %h, required 000001000", bcd_out); end
    endtask

    task automatic test_saturation();
        int u;
        send_block(36'h0_7FFF_FFFF, 4);
        idle(CONV_WAIT, u);
        vs_pulse(u);
        n_checks++; if (u !== 1) begin n_fail++; $display("FAIL sat_upd_count: got %0d, required 1", u); end
        n_checks++; if (bcd_out !== 36'h999999999) begin n_fail++; $display("FAIL sat_bcd: got %h, required 999999999", bcd_out); end
        n_checks++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %b, required 1", sat); end
    endtask

    task automatic test_drop_and_clr();
        int u;
        send_block(36'd500, 4);
        repeat (5) tick();
        send_block(36'd7, 2);
        n_checks++; if (drop_sticky !== 1'b1) begin n_fail++; $display("FAIL drop_in_bcd: got %b, required 1", drop_sticky); end
        idle(CONV_WAIT - 7, u);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy_wait: got %b, required 1", busy); end
        send_block(36'd9, 1);
        vs_pulse(u);
        n_checks++; if (u !== 1) begin n_fail++; $display("FAIL drop_upd_count: got %0d, required 1", u); end
        n_checks++; if (bcd_out !== 36'h000000500) begin n_fail++; $display("FAIL drop_bcd: got %h, required 000000500", bcd_out); end
        n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL drop_sat: got %b, required 0", sat); end
        n_checks++; if (drop_sticky !== 1'b1) begin n_fail++; $display("FAIL drop_sticky_hold: got %b, required 1", drop_sticky); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++; if (drop_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_drop: got %b, required 0", drop_sticky); end
        n_checks++; if (bcd_out !== 36'h000000500) begin n_fail++; $display("FAIL clr_bcd_kept: got %h, required 000000500", bcd_out); end
        n_checks++; if (bcd_upd !== 1'b0) begin n_fail++; $display("FAIL clr_upd: got %b, required 0", bcd_upd); end
        // Abort a conversion mid-way; the sample presented with clr must be neither counted nor dropped.
        send_block(36'd900, 4);
        repeat (10) tick();
        clr        = 1'b1;
        samp_data  = 36'd9999;
        samp_valid = 1'b1;
        tick();
        clr        = 1'b0;
        samp_valid = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_mid_busy: got %b, required 0", busy); end
        n_checks++; if (drop_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_mid_drop: got %b, required 0", drop_sticky); end
        vs_pulse(u);
        n_checks++; if (u !== 0) begin n_fail++; $display("FAIL clr_mid_upd: got %0d, required 0", u); end
        n_checks++; if (bcd_out !== 36'h000000500) begin n_fail++; $display("FAIL clr_mid_bcd: got %h, required 000000500", bcd_out); end
        clr        = 1'b1;
        samp_data  = 36'd9999;
        samp_valid = 1'b1;
        tick();
        clr        = 1'b0;
        samp_valid = 1'b0;
        send_block(36'd123, 4);
        idle(CONV_WAIT, u);
        vs_pulse(u);
        n_checks++; if (u !== 1) begin n_fail++; $display("FAIL clr_same_upd: got %0d, required 1", u); end
        n_checks++; if (bcd_out !== 36'h000000123) begin n_fail++; $display("FAIL clr_same_bcd: got %h, required 000000123", bcd_out); end
    endtask

    task automatic test_vs_held();
        int u;
        int u2;
        send_block(36'd64, 4);
        repeat (36) tick();
        lcd_vs = 1'b1;
        idle(10, u);
        n_checks++; if (u !== 0) begin n_fail++; $display("FAIL vs_held_upd: got %0d, required 0", u); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL vs_held_busy: got %b, required 1", busy); end
        lcd_vs = 1'b0;
        idle(2, u2);
        vs_pulse(u);
        n_checks++; if (u + u2 !== 1) begin n_fail++; $display("FAIL vs_second_edge_upd: got %0d, required 1", u + u2); end
        n_checks++; if (bcd_out !== 36'h000000064) begin n_fail++; $display("FAIL vs_held_bcd: got %h, required 000000064", bcd_out); end
    endtask

    task automatic test_random();
        longint unsigned q[$];
        logic [DATA_W-1:0] v;
        logic [35:0] exp_bcd;
        logic exp_sat;
        logic vld;
        logic c;
        int u;
        int kind;
        for (int it = 0; it < 8; it++) begin
            q.delete();
            while (q.size() < NSAMP) begin
                kind = $urandom_range(0, 3);
                case (kind)
                    0:       v = {5'($urandom_range(1, 31)), 31'($urandom)};
                    1:       v = 36'($urandom_range(0, 99999));
                    2:       v = {5'b0, 31'($urandom)};
                    default: v = 36'($urandom_range(0, 999));
                endcase
                vld = ($urandom_range(0, 3) != 0);
                c   = ($urandom_range(0, 15) == 0);
                samp_data  = v;
                samp_valid = vld;
                clr        = c;
                if (c) q.delete();
                else if (vld && v[DATA_W-1 -: REJECT_BITS] == '0) q.push_back(64'(v));
                tick();
            end
            samp_valid = 1'b0;
            clr        = 1'b0;
            exp_bcd = model_bcd(q, exp_sat);
            idle(CONV_WAIT, u);
            vs_pulse(u);
            n_checks++; if (u !== 1) begin n_fail++; $display("FAIL rand%0d_upd: got %0d, required 1", it, u); end
            n_checks++; if (bcd_out !== exp_bcd) begin n_fail++; $display("FAIL rand%0d_bcd: got %h, required %h", it, bcd_out, exp_bcd); end
            n_checks++; if (sat !== exp_sat) begin n_fail++; $display("FAIL rand%0d_sat: got %b, required %b", it, sat, exp_sat); end
        end
    endtask

    task automatic test_reset_mid();
        int u;
        send_block(36'd321, 4);
        idle(CONV_WAIT, u);
        vs_pulse(u);
        n_checks++; if (bcd_out !== 36'h000000321) begin n_fail++; $display("FAIL rmid_pre_bcd: got %h, required 000000321", bcd_out); end
        send_block(36'd555, 4);
        repeat (10) tick();
        #2;
        sys_rst_n = 1'b0;
        #1;
        n_checks++; if (bcd_out !== 36'h0) begin n_fail++; $display("FAIL rmid_bcd: got %h, required 0", bcd_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b, required 0", busy); end
        tick();
        sys_rst_n = 1'b1;
        tick();
        send_block(36'd42, 4);
        idle(CONV_WAIT, u);
        vs_pulse(u);
        n_checks++; if (bcd_out !== 36'h000000042) begin n_fail++; $display("FAIL rmid_recover_bcd: got %h, required 000000042", bcd_out); end
    endtask

`ifdef FRE_PEAK_HOLD_EN
    task automatic test_peak();
        logic [DATA_W-1:0] vals [4];
        int u;
        vals = '{36'd5, 36'd90, 36'd40, 36'd7};
        for (int i = 0; i < 4; i++) send_block(vals[i], 1);
        idle(CONV_WAIT, u);
        vs_pulse(u);
        n_checks++; if (bcd_out !== 36'h000000090) begin n_fail++; $display("FAIL peak_bcd: got %h, required 000000090", bcd_out); end
        n_checks++; if (u !== 1) begin n_fail++; $display("FAIL peak_upd: got %0d, required 1", u); end
    endtask
`endif

    initial begin
        test_reset();
        test_average();
        test_reject();
        test_saturation();
        test_drop_and_clr();
        test_vs_held();
        test_random();
        test_reset_mid();
`ifdef FRE_PEAK_HOLD_EN
        test_peak();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fre_meas_scheduler.md
Name: fre_meas_scheduler

Overview:
- Sequences the frequency-readout path of the oscilloscope overlay: accumulates 2^AVG_LOG2 accepted FFT frequency samples, averages them and converts the average to packed BCD with a multi-cycle double-dabble.
- Publishes the nine digits to the LCD character-overlay block only at a frame boundary, so a digit never changes mid-frame.
- Sits between the FFT peak-frequency output and the frequency text renderer, in the lcd_pclk domain.

Parameters:
- DATA_W, 36, width of incoming frequency sample.
- AVG_LOG2, 10, log2 of the number of accepted samples averaged per result.
- REJECT_BITS, 5, number of MSBs of the sample that must be zero for it to be accepted.
- DIGITS, 9, number of BCD digits published; the result saturates to all nines.

Ports:
- lcd_pclk  in  1  pixel clock; all logic on its rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- samp_data  in  DATA_W  frequency sample from the FFT stage.
- samp_valid  in  1  samp_data is valid this cycle.
- lcd_vs  in  1  LCD vertical sync, active high; the rising edge marks the frame boundary.
- clr  in  1  synchronous restart; discards the in-progress accumulation.
- bcd_out  out  4*DIGITS  published digits; digit 0 is in bits [3:0].
- bcd_upd  out  1  one-cycle pulse when bcd_out changes.
- busy  out  1  high in any state other than ACCUM.
- sat  out  1  the last published value was saturated.
- drop_sticky  out  1  a valid sample arrived while not in ACCUM; cleared by clr.

Behaviour:
- Reset values: all outputs 0; state ACCUM; accumulator, sample counter and lcd_vs edge register all 0.
- Accumulator width is DATA_W+AVG_LOG2. The counter is AVG_LOG2+1 bits wide.
- ACCUM:
  - A sample is accepted when samp_valid=1 and samp_data[DATA_W-1 -: REJECT_BITS]==0. An accepted sample is added and the counter increments.
  - A rejected sample changes nothing and is not counted.
  - When the counter reaches 2^AVG_LOG2 (the add of the last sample completes in that same cycle), the next state is AVG.
- AVG (1 cycle):
  - avg = acc >> AVG_LOG2, truncating.
  - If avg > 10^DIGITS-1, the conversion input is forced to 10^DIGITS-1 and sat_n=1. Otherwise sat_n=0.
  - Clear the accumulator and counter. Go to BCD.
- BCD:
  - Double-dabble conversion, one shift per cycle, exactly DATA_W cycles, with add-3 correction before each shift.
  - Then go to WAIT_VS.
- WAIT_VS:
  - Hold the converted result.
  - On the first cycle where lcd_vs=1 and the registered lcd_vs_d=0: bcd_out<=result, sat<=sat_n, bcd_upd=1 in the following cycle, go to ACCUM.
  - If the rising edge occurs on the very cycle BCD finishes, it is not seen; wait for the next frame.
- Latency: last accepted sample to bcd_upd is 1 (AVG) + DATA_W (BCD) + the wait for the vsync edge + 1.
- Samples arriving in AVG, BCD or WAIT_VS are dropped and set drop_sticky. Samples are never buffered.
- clr has priority over every state:
  - Return to ACCUM with accumulator and counter zeroed; clear drop_sticky.
  - bcd_out and sat keep their last values; no bcd_upd.
- Asynchronous reset mid-conversion discards everything; bcd_out returns to 0.
- samp_valid in the same cycle as clr: the sample is discarded.

Optional Feature:
- Macro FRE_PEAK_HOLD_EN.
- Defined: ACCUM tracks the maximum accepted sample instead of summing, and AVG uses that maximum with no shift. The maximum register resets at each AVG and on clr.
- Undefined: mean behaviour as above, and no maximum register is synthesised.

Decomposition:
- Package fre_meas_pkg holds:
  - the state enum {ACCUM, AVG, BCD, WAIT_VS};
  - the DIGITS constant and BCD_MAX = 10^DIGITS-1 as a DATA_W-wide constant;
  - the add-3 function.
- One sub-module, bin2bcd_seq:
  - Sequential double-dabble with start/done handshake.
  - Ports: start, bin[DATA_W-1:0], done pulse, bcd[4*DIGITS-1:0].
  - start is ignored while it is running.

Test Plan:
- AVG_LOG2=2, samples 100,200,300,400 valid back-to-back, then a vsync edge → bcd_out=0x000000250, bcd_upd single pulse, sat=0.
- Samples with bits[35:31]!=0 interleaved with four samples of 1000 → rejected samples ignored, result 0x000001000.
- Four samples of 36'h0_7FFF_FFFF (2147483647, MSBs clear) → average > 999999999, so bcd_out=0x999999999 and sat=1.
- Valid samples during BCD and WAIT_VS → drop_sticky=1, result unchanged. Then clr → drop_sticky=0 and bcd_out kept.
- lcd_vs held high through BCD completion → no publish until lcd_vs falls and rises again; exactly one bcd_upd.
- With FRE_PEAK_HOLD_EN: samples 5,90,40,7 → bcd_out=0x000000090.
